// File: rtl/addsub_arbiter.sv
// addsub_arbiter: shares one registered W-bit add/subtract datapath between
// two requesters using round-robin arbitration and a req/ack handshake.
//
// Each operation walks IDLE -> EXEC -> DONE. The ack pulse is registered on
// the DONE -> IDLE edge, so it is visible in the first IDLE cycle. A request
// sampled at edge k therefore acks in the cycle after edge k+2. A requester
// that keeps req high is re-sampled on that same ack edge, which gives one
// operation every 3 cycles.
//
// Optional statistics: define ADDSUB_ARB_STATS_EN to add the cnt0/cnt1
// completion counters and the sticky both_req contention flag.

module addsub_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         op0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic         op1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         ack0,
  output logic         ack1,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf,
  output logic         busy
`ifdef ADDSUB_ARB_STATS_EN
  ,
  output logic [7:0]   cnt0,
  output logic [7:0]   cnt1,
  output logic         both_req
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q,  state_d;
  logic         ptr_q,    ptr_d;
  logic         winner_q, winner_d;
  logic         op_q,     op_d;
  logic [W-1:0] a_q,      a_d;
  logic [W-1:0] b_q,      b_d;
  logic [W-1:0] result_q, result_d;
  logic         cout_q,   cout_d;
  logic         ovf_q,    ovf_d;
  logic         ack0_q,   ack0_d;
  logic         ack1_q,   ack1_d;
  logic         busy_q,   busy_d;

`ifdef ADDSUB_ARB_STATS_EN
  logic [7:0]   cnt0_q,     cnt0_d;
  logic [7:0]   cnt1_q,     cnt1_d;
  logic         both_req_q, both_req_d;
`endif

  logic         grant1;
  logic [W:0]   sum_ext;
  logic [W:0]   diff_ext;
  logic         add_ovf;
  logic         sub_ovf;

  // Datapath: a W+1-bit sum and difference built from the captured operands
  // only, so input changes during EXEC cannot disturb the in-flight result.
  // Bit W is the carry for add and the borrow (A < B unsigned) for sub.
  always_comb begin
    sum_ext  = {1'b0, a_q} + {1'b0, b_q};
    diff_ext = {1'b0, a_q} - {1'b0, b_q};
    add_ovf  = (a_q[W-1] == b_q[W-1]) && (sum_ext[W-1]  != a_q[W-1]);
    sub_ovf  = (a_q[W-1] != b_q[W-1]) && (diff_ext[W-1] != a_q[W-1]);
  end

  // Next-state logic: arbitration and operand capture in IDLE, result capture
  // in EXEC, ack and pointer update in DONE. The pointer is set to the port
  // that did not win, so two held requests strictly alternate.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    grant1   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant1   = req1 && (!req0 || ptr_q);
          winner_d = grant1;
          op_d     = grant1 ? op1 : op0;
          a_d      = grant1 ? a1  : a0;
          b_d      = grant1 ? b1  : b0;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (op_q) begin
          result_d = diff_ext[W-1:0];
          cout_d   = diff_ext[W];
          ovf_d    = sub_ovf;
        end else begin
          result_d = sum_ext[W-1:0];
          cout_d   = sum_ext[W];
          ovf_d    = add_ovf;
        end
        state_d = DONE;
      end
      DONE: begin
        ack0_d  = !winner_q;
        ack1_d  = winner_q;
        ptr_d   = !winner_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

`ifdef ADDSUB_ARB_STATS_EN
  // Statistics: the counters step on the same edge that raises the ack, and
  // the contention flag latches any IDLE cycle in which both ports request.
  always_comb begin
    cnt0_d     = cnt0_q + (ack0_d ? 8'd1 : 8'd0);
    cnt1_d     = cnt1_q + (ack1_d ? 8'd1 : 8'd0);
    both_req_d = both_req_q || ((state_q == IDLE) && req0 && req1);
  end
`endif

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      winner_q   <= 1'b0;
      op_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef ADDSUB_ARB_STATS_EN
      cnt0_q     <= 8'd0;
      cnt1_q     <= 8'd0;
      both_req_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      winner_q   <= winner_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      busy_q     <= busy_d;
`ifdef ADDSUB_ARB_STATS_EN
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      both_req_q <= both_req_d;
`endif
    end
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign busy   = busy_q;

`ifdef ADDSUB_ARB_STATS_EN
  assign cnt0     = cnt0_q;
  assign cnt1     = cnt1_q;
  assign both_req = both_req_q;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed testbench for addsub_arbiter (W=4) with hand-computed expectations.
// When ADDSUB_ARB_STATS_EN is defined, the statistics outputs are also checked.

module tb_addsub_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, op0 = 1'b0;
  logic [3:0] a0 = '0, b0 = '0;
  logic       req1 = 1'b0, op1 = 1'b0;
  logic [3:0] a1 = '0, b1 = '0;
  logic       ack0, ack1, cout, ovf, busy;
  logic [3:0] result;
`ifdef ADDSUB_ARB_STATS_EN
  logic [7:0] cnt0, cnt1;
  logic       both_req;
`endif

  int checks   = 0;
  int failures = 0;

  addsub_arbiter #(.W(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .result(result),
    .cout(cout), .ovf(ovf), .busy(busy)
`ifdef ADDSUB_ARB_STATS_EN
    , .cnt0(cnt0), .cnt1(cnt1), .both_req(both_req)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts one comparison and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Resets the DUT for two edges.
  task automatic doReset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Waits (bounded) for an ack and checks busy and ack exclusivity on each cycle.
  task automatic waitAck(input string tag, output int which, output int lat);
    which = -1;
    lat   = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      checkOutput({tag, "_excl"}, {31'b0, ack0 & ack1}, 32'd0);
      if (ack0 || ack1) begin
        which = ack1 ? 1 : 0;
        lat   = i;
        checkOutput({tag, "_busy_ack"}, {31'b0, busy}, 32'd0);
        break;
      end
      checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd1);
    end
  endtask

  // Issues one request on one port and checks the acked result.
  task automatic applyStimulus(input string tag, input int port, input logic op,
                               input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] expRes, input logic expCout,
                               input logic expOvf);
    int which, lat;
    if (port == 0) begin
      op0 = op; a0 = a; b0 = b; req0 = 1'b1;
    end else begin
      op1 = op; a1 = a; b1 = b; req1 = 1'b1;
    end
    waitAck(tag, which, lat);
    checkOutput({tag, "_port"}, which, port);
    checkOutput({tag, "_lat"}, lat, 32'd3);
    checkOutput({tag, "_res"}, {28'b0, result}, {28'b0, expRes});
    checkOutput({tag, "_cout"}, {31'b0, cout}, {31'b0, expCout});
    checkOutput({tag, "_ovf"}, {31'b0, ovf}, {31'b0, expOvf});
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    checkOutput({tag, "_ackoff"}, {30'b0, ack0, ack1}, 32'd0);
  endtask

  initial begin
    int which, lat;

    doReset();
    #1;
    checkOutput("rst_ack", {30'b0, ack0, ack1}, 32'd0);
    checkOutput("rst_res", {28'b0, result}, 32'd0);
    checkOutput("rst_flags", {30'b0, cout, ovf}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);

    // Single-port operations.
    applyStimulus("add_7_5", 0, 1'b0, 4'd7, 4'd5, 4'd12, 1'b0, 1'b1);
    applyStimulus("add_9_8", 1, 1'b0, 4'd9, 4'd8, 4'd1,  1'b1, 1'b1);
    applyStimulus("sub_3_5", 0, 1'b1, 4'd3, 4'd5, 4'hE,  1'b1, 1'b0);

    // Pointer now favours port 1; reset in EXEC of a port-1 request.
    op1 = 1'b0; a1 = 4'd9; b1 = 4'd8; req1 = 1'b1;
    step();
    checkOutput("abort_exec_busy", {31'b0, busy}, 32'd1);
    rst  = 1'b1;
    req1 = 1'b0;
    step();
    rst = 1'b0;
    checkOutput("abort_res", {28'b0, result}, 32'd0);
    checkOutput("abort_flags", {30'b0, cout, ovf}, 32'd0);
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("abort_noack", {30'b0, ack0, ack1}, 32'd0);
    end

    // Both held for four operations: strict alternation starting at port 0.
    op0 = 1'b0; a0 = 4'd1; b0 = 4'd1; req0 = 1'b1;
    op1 = 1'b1; a1 = 4'd6; b1 = 4'd2; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      waitAck("rr", which, lat);
      checkOutput("rr_port", which, i % 2);
      checkOutput("rr_lat", lat, 32'd3);
      checkOutput("rr_res", {28'b0, result}, (i % 2 == 0) ? 32'd2 : 32'd4);
      checkOutput("rr_flags", {30'b0, cout, ovf}, 32'd0);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    checkOutput("rr_ackoff", {30'b0, ack0, ack1}, 32'd0);

`ifdef ADDSUB_ARB_STATS_EN
    doReset();
    checkOutput("st_rst_cnt", {16'b0, cnt0, cnt1}, 32'd0);
    checkOutput("st_rst_both", {31'b0, both_req}, 32'd0);
    applyStimulus("st_a", 0, 1'b0, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0);
    applyStimulus("st_b", 0, 1'b0, 4'd2, 4'd2, 4'd4, 1'b0, 1'b0);
    applyStimulus("st_c", 1, 1'b1, 4'd5, 4'd1, 4'd4, 1'b0, 1'b0);
    checkOutput("st_both_pre", {31'b0, both_req}, 32'd0);
    // One contention: pointer is back at port 0 after the port-1 win.
    op0 = 1'b0; a0 = 4'd1; b0 = 4'd1; req0 = 1'b1;
    op1 = 1'b0; a1 = 4'd2; b1 = 4'd2; req1 = 1'b1;
    waitAck("st_ct0", which, lat);
    checkOutput("st_ct0_port", which, 32'd0);
    req0 = 1'b0;
    waitAck("st_ct1", which, lat);
    checkOutput("st_ct1_port", which, 32'd1);
    checkOutput("st_ct1_res", {28'b0, result}, 32'd4);
    req1 = 1'b0;
    step();
    checkOutput("st_cnt0", {24'b0, cnt0}, 32'd3);
    checkOutput("st_cnt1", {24'b0, cnt1}, 32'd2);
    checkOutput("st_both", {31'b0, both_req}, 32'd1);
    for (int i = 0; i < 256; i++)
      applyStimulus("st_wrap", 0, 1'b0, 4'd3, 4'd3, 4'd6, 1'b0, 1'b0);
    checkOutput("st_wrap_cnt0", {24'b0, cnt0}, 32'd3);
    checkOutput("st_wrap_cnt1", {24'b0, cnt1}, 32'd2);
    checkOutput("st_wrap_both", {31'b0, both_req}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
